// File: rtl/transaction_arbiter.sv
// Round-robin arbiter sharing one transaction pipeline among N_REQ requesters,
// with step-code completion tracking and a watchdog that aborts hung transactions.
module transaction_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16,
  parameter logic [CNT_W-1:0] TIMEOUT = 16'd50000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [N_REQ-1:0]  req,
  input  logic [2:0]        step,
  output logic              start_transaction,
  output logic              pipe_flush,
  output logic [N_REQ-1:0]  grant,
  output logic [ID_W-1:0]   grant_id,
  output logic [N_REQ-1:0]  txn_done,
  output logic [N_REQ-1:0]  txn_abort,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_RUN,
    S_COMPLETE,
    S_ABORT
  } state_t;

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  localparam logic [2:0] STEP_NONE   = 3'b000;
  localparam logic [2:0] STEP_FINISH = 3'b100;

  state_t           state, nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] wd;
  logic             seen_finish;
  logic [ID_W-1:0]  win;
  logic             found;
  int unsigned      idx;

  // Search starts just above the previous owner so it is served last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % N_REQ;
      if (!found && req[ID_W'(idx)]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:       if (found && step == STEP_NONE) nxt = S_ISSUE;
      S_ISSUE:      nxt = S_WAIT_START;
      S_WAIT_START: begin
        if (wd == TIMEOUT)           nxt = S_ABORT;
        else if (step != STEP_NONE)  nxt = S_RUN;
      end
      S_RUN: begin
        if (wd == TIMEOUT)                           nxt = S_ABORT;
        else if (seen_finish && step == STEP_NONE)   nxt = S_COMPLETE;
      end
      S_COMPLETE:   nxt = S_IDLE;
      S_ABORT:      nxt = S_IDLE;
      default:      nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start_transaction = (state == S_ISSUE);
    pipe_flush        = (state == S_ABORT);
    txn_done          = (state == S_COMPLETE) ? grant : '0;
    txn_abort         = (state == S_ABORT)    ? grant : '0;
    busy              = (state != S_IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= nxt;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      grant       <= '0;
      grant_id    <= '0;
      rr_ptr      <= ID_W'(N_REQ - 1);
      wd          <= '0;
      seen_finish <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (nxt == S_ISSUE) begin
            grant    <= ONE << win;
            grant_id <= win;
          end
        end
        S_ISSUE: begin
          wd          <= '0;
          seen_finish <= 1'b0;
        end
        S_WAIT_START: begin
          if (wd != '1) wd <= wd + 1'b1;
        end
        S_RUN: begin
          if (wd != '1) wd <= wd + 1'b1;
          if (step == STEP_FINISH) seen_finish <= 1'b1;
        end
        S_COMPLETE, S_ABORT: begin
          rr_ptr <= grant_id;
          grant  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_transaction_arbiter.sv
// Directed self-checking bench for transaction_arbiter (N_REQ=4, TIMEOUT=100).
module tb_transaction_arbiter;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] req;
  logic [2:0] step;
  logic       start_transaction, pipe_flush, busy;
  logic [3:0] grant, txn_done, txn_abort;
  logic [1:0] grant_id;

  int checks   = 0;
  int failures = 0;

  transaction_arbiter #(
    .N_REQ(4),
    .ID_W(2),
    .CNT_W(16),
    .TIMEOUT(16'd100)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .req(req),
    .step(step),
    .start_transaction(start_transaction),
    .pipe_flush(pipe_flush),
    .grant(grant),
    .grant_id(grant_id),
    .txn_done(txn_done),
    .txn_abort(txn_abort),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req    = '0;
    step   = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  // From the ISSUE cycle: step 001 -> 100 -> 000, then expect txn_done and return to idle.
  task automatic finish_txn(input int id, input string tag);
    tick();
    check({tag, "_wait_start"}, start_transaction, 0);
    step = 3'b001;
    tick();
    check({tag, "_run_grant"}, grant, 32'(1) << id);
    step = 3'b100;
    tick();
    step = 3'b000;
    tick();
    check({tag, "_done"}, txn_done, 32'(1) << id);
    check({tag, "_no_abort"}, txn_abort, 0);
    tick();
    check({tag, "_done_clear"}, txn_done, 0);
    check({tag, "_grant_clear"}, grant, 0);
  endtask

  task automatic issue(input int id, input string tag);
    tick();
    check({tag, "_start"}, start_transaction, 1);
    check({tag, "_grant_id"}, grant_id, id);
    check({tag, "_grant"}, grant, 32'(1) << id);
    check({tag, "_busy"}, busy, 1);
  endtask

  initial begin
    int n;
    int exp_ids[5];
    exp_ids = '{0, 1, 2, 3, 0};

    // Reset state
    do_reset();
    check("rst_grant", grant, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_start", start_transaction, 0);
    check("rst_flush", pipe_flush, 0);
    check("rst_done", txn_done, 0);

    // 1: single requester, full step walk
    req = 4'b0001;
    issue(0, "t1");
    req = 4'b0000;
    finish_txn(0, "t1");
    check("t1_busy_low", busy, 0);

    // 2: all requesting, round-robin 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      issue(exp_ids[k], $sformatf("t2_%0d", k));
      finish_txn(exp_ids[k], $sformatf("t2_%0d", k));
      check($sformatf("t2_%0d_idle", k), busy, 0);
    end
    req = 4'b0000;

    // 3: watchdog. Counter is 0 in the first WAIT_START cycle and compared
    // before increment, so ABORT lands TIMEOUT+2 cycles after ISSUE.
    do_reset();
    req = 4'b0100;
    issue(2, "t3");
    n = 0;
    while (txn_abort == 4'b0000 && n < 200) begin
      tick();
      n++;
    end
    check("t3_abort_delay", n, 102);
    check("t3_abort", txn_abort, 4'b0100);
    check("t3_flush", pipe_flush, 1);
    check("t3_no_done", txn_done, 0);
    req = 4'b0000;
    tick();
    check("t3_abort_clear", txn_abort, 0);
    check("t3_flush_clear", pipe_flush, 0);
    check("t3_grant_clear", grant, 0);

    // 4: pipeline not in buffer blocks issue
    do_reset();
    step = 3'b011;
    req  = 4'b0010;
    repeat (3) tick();
    check("t4_no_start", start_transaction, 0);
    check("t4_idle", busy, 0);
    step = 3'b000;
    issue(1, "t4");
    req = 4'b0000;
    finish_txn(1, "t4");

    // 5: reset mid-RUN, then rr_ptr back at 3 so index 0 wins
    do_reset();
    req = 4'b1000;
    issue(3, "t5");
    tick();
    step = 3'b001;
    tick();
    check("t5_run_grant", grant, 4'b1000);
    #2 resetn = 1'b0;
    #1;
    check("t5_async_grant", grant, 0);
    check("t5_async_id", grant_id, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_done", txn_done, 0);
    check("t5_async_abort", txn_abort, 0);
    #1 resetn = 1'b1;
    step = 3'b000;
    req  = 4'b1001;
    issue(0, "t5_after");
    req = 4'b1000;
    finish_txn(0, "t5_after");
    issue(3, "t5_next");
    req = 4'b0000;
    finish_txn(3, "t5_next");

    // 6: owner drops req during RUN; next grant goes above index 1
    do_reset();
    req = 4'b0010;
    issue(1, "t6");
    tick();
    step = 3'b001;
    tick();
    req  = 4'b1101;
    step = 3'b100;
    tick();
    step = 3'b000;
    tick();
    check("t6_done", txn_done, 4'b0010);
    tick();
    check("t6_idle", busy, 0);
    issue(2, "t6_next");
    req = 4'b0000;
    finish_txn(2, "t6_next");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
